// File: rtl/db_tupu_ram_ctrl_pkg.sv
// Shared sizing and FSM encodings for the deblocking top-PU buffer controller.
package db_tupu_ram_ctrl_pkg;

    localparam int          TUPU_ADR_W   = 6;
    localparam int          TUPU_DAT_W   = 32;
    localparam logic [31:0] TUPU_CLR_VAL = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CLR  = 1'b1
    } state_t;

endpackage

// File: rtl/db_tupu_ram_ctrl.sv
// Arbitrates a write port and a read port onto the single-port top-PU buffer, with a clear sweep.
// Optional macro DB_TUPU_FWD_EN forwards pending/same-cycle write data to colliding reads.
module db_tupu_ram_ctrl
    import db_tupu_ram_ctrl_pkg::*;
#(
    parameter int               ADR_W   = TUPU_ADR_W,
    parameter int               DAT_W   = TUPU_DAT_W,
    parameter logic [DAT_W-1:0] CLR_VAL = DAT_W'(TUPU_CLR_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_start_i,
    output logic             busy_o,
    output logic             clr_done_o,
    input  logic             wr_req_i,
    input  logic [ADR_W-1:0] wr_adr_i,
    input  logic [DAT_W-1:0] wr_dat_i,
    output logic             wr_rdy_o,
    input  logic             rd_req_i,
    input  logic [ADR_W-1:0] rd_adr_i,
    output logic             rd_rdy_o,
    output logic             rd_vld_o,
    output logic [DAT_W-1:0] rd_dat_o,
    output logic             ram_cen_o,
    output logic             ram_wen_o,
    output logic [ADR_W-1:0] ram_adr_o,
    output logic [DAT_W-1:0] ram_wr_dat_o,
    input  logic [DAT_W-1:0] ram_rd_dat_i
);

    state_t             state;
    state_t             state_nxt;
    logic [ADR_W-1:0]   clr_cnt;
    logic               clr_last;
    logic               wb_vld;
    logic [ADR_W-1:0]   wb_adr;
    logic [DAT_W-1:0]   wb_dat;
    logic               rd_acc;
    logic               wr_acc;
    logic               drain;
    logic               clr_go;

    assign clr_last = (clr_cnt == {ADR_W{1'b1}});
    assign clr_go   = (state == ST_IDLE) && clr_start_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A clear request wins the cycle outright: neither port is accepted alongside it.
    always_comb begin
        state_nxt    = state;
        busy_o       = 1'b0;
        rd_rdy_o     = 1'b0;
        wr_rdy_o     = 1'b0;
        rd_acc       = 1'b0;
        wr_acc       = 1'b0;
        drain        = 1'b0;
        ram_cen_o    = 1'b1;
        ram_wen_o    = 1'b1;
        ram_adr_o    = '0;
        ram_wr_dat_o = '0;
        case (state)
            ST_IDLE: begin
                if (clr_start_i) begin
                    state_nxt = ST_CLR;
                end else begin
                    rd_rdy_o = 1'b1;
                    wr_rdy_o = ~wb_vld;
                    rd_acc   = rd_req_i;
                    wr_acc   = wr_req_i & ~wb_vld;
                    if (rd_acc) begin
                        ram_cen_o = 1'b0;
                        ram_adr_o = rd_adr_i;
                    end else if (wb_vld) begin
                        drain        = 1'b1;
                        ram_cen_o    = 1'b0;
                        ram_wen_o    = 1'b0;
                        ram_adr_o    = wb_adr;
                        ram_wr_dat_o = wb_dat;
                    end else if (wr_acc) begin
                        ram_cen_o    = 1'b0;
                        ram_wen_o    = 1'b0;
                        ram_adr_o    = wr_adr_i;
                        ram_wr_dat_o = wr_dat_i;
                    end
                end
            end
            ST_CLR: begin
                busy_o       = 1'b1;
                ram_cen_o    = 1'b0;
                ram_wen_o    = 1'b0;
                ram_adr_o    = clr_cnt;
                ram_wr_dat_o = CLR_VAL;
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p1: control registers (sweep counter, buffer valid, read valid, done pulse).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt    <= '0;
            wb_vld     <= 1'b0;
            rd_vld_o   <= 1'b0;
            clr_done_o <= 1'b0;
        end else begin
            clr_done_o <= (state == ST_CLR) && clr_last;
            rd_vld_o   <= rd_acc;
            if (state == ST_CLR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
            if (clr_go) begin
                wb_vld <= 1'b0;
            end else if (rd_acc && wr_acc) begin
                wb_vld <= 1'b1;
            end else if (drain) begin
                wb_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc && wr_acc) begin
            wb_adr <= wr_adr_i;
            wb_dat <= wr_dat_i;
        end
    end

`ifdef DB_TUPU_FWD_EN
    logic             hit_wr;
    logic             hit_wb;
    logic             fwd_sel_p1;
    logic [DAT_W-1:0] fwd_dat_p1;

    // A same-cycle write and a buffered write never coexist (wr_rdy is low while buffered).
    assign hit_wr = wr_acc && (wr_adr_i == rd_adr_i);
    assign hit_wb = wb_vld && (wb_adr == rd_adr_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_sel_p1 <= 1'b0;
        end else begin
            fwd_sel_p1 <= rd_acc && (hit_wr || hit_wb);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            fwd_dat_p1 <= hit_wr ? wr_dat_i : wb_dat;
        end
    end

    assign rd_dat_o = fwd_sel_p1 ? fwd_dat_p1 : ram_rd_dat_i;
`else
    assign rd_dat_o = ram_rd_dat_i;
`endif

endmodule

// File: tb/tb_db_tupu_ram_ctrl.sv
// Scoreboard bench for db_tupu_ram_ctrl with a behavioural single-port RAM beside it.
module tb_db_tupu_ram_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_start_i;
    logic          busy_o;
    logic          clr_done_o;
    logic          wr_req_i;
    logic [AW-1:0] wr_adr_i;
    logic [DW-1:0] wr_dat_i;
    logic          wr_rdy_o;
    logic          rd_req_i;
    logic [AW-1:0] rd_adr_i;
    logic          rd_rdy_o;
    logic          rd_vld_o;
    logic [DW-1:0] rd_dat_o;
    logic          ram_cen_o;
    logic          ram_wen_o;
    logic [AW-1:0] ram_adr_o;
    logic [DW-1:0] ram_wr_dat_o;
    logic [DW-1:0] ram_rd_dat_i;

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ram_mem   [64];
    logic [DW-1:0] model_mem [64];
    logic          pend;
    logic [AW-1:0] pend_adr;
    logic [DW-1:0] pend_dat;

    always #5 clk = ~clk;

    db_tupu_ram_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_start_i  (clr_start_i),
        .busy_o       (busy_o),
        .clr_done_o   (clr_done_o),
        .wr_req_i     (wr_req_i),
        .wr_adr_i     (wr_adr_i),
        .wr_dat_i     (wr_dat_i),
        .wr_rdy_o     (wr_rdy_o),
        .rd_req_i     (rd_req_i),
        .rd_adr_i     (rd_adr_i),
        .rd_rdy_o     (rd_rdy_o),
        .rd_vld_o     (rd_vld_o),
        .rd_dat_o     (rd_dat_o),
        .ram_cen_o    (ram_cen_o),
        .ram_wen_o    (ram_wen_o),
        .ram_adr_o    (ram_adr_o),
        .ram_wr_dat_o (ram_wr_dat_o),
        .ram_rd_dat_i (ram_rd_dat_i)
    );

    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) ram_mem[ram_adr_o] <= ram_wr_dat_o;
            else            ram_rd_dat_i <= ram_mem[ram_adr_o];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (clr_done_o) done_cnt++;
            if (rd_vld_o) begin
                rd_cnt++;
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else                   chk("rd_dat", rd_dat_o, exp_q.pop_front());
            end
        end
    end

    // One IDLE cycle: drive at posedge+1, check RAM port against the priority model at negedge.
    task automatic step(input bit rd, input logic [AW-1:0] ra,
                        input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        bit            wr_acc;
        logic [DW-1:0] e;
        rd_req_i = rd; rd_adr_i = ra;
        wr_req_i = wr; wr_adr_i = wa; wr_dat_i = wd;
        @(negedge clk);
        chk("rd_rdy", rd_rdy_o, 1);
        chk("wr_rdy", wr_rdy_o, !pend);
        wr_acc = wr && !pend;
        if (rd) begin
            chk("rd_cen", ram_cen_o, 0);
            chk("rd_wen", ram_wen_o, 1);
            chk("rd_adr", ram_adr_o, ra);
            e = model_mem[ra];
`ifdef DB_TUPU_FWD_EN
            if (wr_acc && wa == ra)        e = wd;
            else if (pend && pend_adr == ra) e = pend_dat;
`endif
            exp_q.push_back(e);
            if (wr_acc) begin
                pend = 1'b1; pend_adr = wa; pend_dat = wd;
            end
        end else if (pend) begin
            chk("drain_wen", ram_wen_o, 0);
            chk("drain_adr", ram_adr_o, pend_adr);
            chk("drain_dat", ram_wr_dat_o, pend_dat);
            model_mem[pend_adr] = pend_dat;
            pend = 1'b0;
        end else if (wr_acc) begin
            chk("wt_cen", ram_cen_o, 0);
            chk("wt_wen", ram_wen_o, 0);
            chk("wt_adr", ram_adr_o, wa);
            chk("wt_dat", ram_wr_dat_o, wd);
            model_mem[wa] = wd;
        end else begin
            chk("idle_cen", ram_cen_o, 1);
            chk("idle_wen", ram_wen_o, 1);
        end
        @(posedge clk); #1;
        rd_req_i = 1'b0; wr_req_i = 1'b0;
    endtask

    task automatic do_clear(input int abort_at);
        int d0;
        clr_start_i = 1'b1;
        rd_req_i = 1'b1; rd_adr_i = 6'd3;
        @(negedge clk);
        chk("clr_go_cen", ram_cen_o, 1);
        @(posedge clk); #1;
        clr_start_i = 1'b0; rd_req_i = 1'b0;
        pend = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy_o, 0);
                chk("rst_cen", ram_cen_o, 1);
                chk("rst_wen", ram_wen_o, 1);
                chk("rst_adr", ram_adr_o, 0);
                chk("rst_wdat", ram_wr_dat_o, 0);
                chk("rst_rdvld", rd_vld_o, 0);
                @(posedge clk); @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_wr_rdy", wr_rdy_o, 1);
                d0 = done_cnt;
                repeat (70) @(negedge clk);
                chk("rst_no_done", done_cnt - d0, 0);
                @(posedge clk); #1;
                return;
            end
            clr_start_i = (i == 10);
            @(negedge clk);
            chk("clr_busy", busy_o, 1);
            chk("clr_cen", ram_cen_o, 0);
            chk("clr_wen", ram_wen_o, 0);
            chk("clr_adr", ram_adr_o, i);
            chk("clr_dat", ram_wr_dat_o, 0);
            chk("clr_rdy", {wr_rdy_o, rd_rdy_o}, 0);
            @(posedge clk); #1;
        end
        clr_start_i = 1'b0;
        @(negedge clk);
        chk("clr_done", clr_done_o, 1);
        chk("clr_busy_end", busy_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_done_once", clr_done_o, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 64; i++) model_mem[i] = '0;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i]   = $urandom;
            model_mem[i] = 'x;
        end
        pend = 1'b0; pend_adr = '0; pend_dat = '0;
        rst_n = 1'b0; clr_start_i = 1'b0;
        wr_req_i = 1'b0; wr_adr_i = '0; wr_dat_i = '0;
        rd_req_i = 1'b0; rd_adr_i = '0;

        @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", clr_done_o, 0);
        chk("reset_rdvld", rd_vld_o, 0);
        chk("reset_cen", ram_cen_o, 1);
        chk("reset_wen", ram_wen_o, 1);
        chk("reset_adr", ram_adr_o, 0);
        chk("reset_wdat", ram_wr_dat_o, 0);
        chk("reset_wr_rdy", wr_rdy_o, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full clear sweep, then read back the last address.
        do_clear(-1);
        step(1, 6'd63, 0, '0, '0);
        step(0, '0, 0, '0, '0);

        // Write, idle, read back.
        step(0, '0, 1, 6'd5, 32'hDEAD_BEEF);
        step(0, '0, 0, '0, '0);
        step(1, 6'd5, 0, '0, '0);
        step(0, '0, 0, '0, '0);

        // Simultaneous read and write to different addresses.
        step(1, 6'd1, 1, 6'd2, 32'h1234_5678);
        step(0, '0, 0, '0, '0);
        step(1, 6'd2, 0, '0, '0);
        step(0, '0, 0, '0, '0);

        // Same-address collision.
        step(1, 6'd2, 1, 6'd2, 32'hA5A5_A5A5);
        step(0, '0, 0, '0, '0);
        step(1, 6'd2, 0, '0, '0);
        step(0, '0, 0, '0, '0);

        // Ten reads starve a buffered write while another write keeps knocking.
        c0 = rd_cnt;
        step(1, 6'd20, 1, 6'd11, 32'h0BAD_F00D);
        for (int i = 1; i < 10; i++) step(1, AW'(20 + i), 1, 6'd12, 32'hCAFE_0012);
        step(0, '0, 1, 6'd12, 32'hCAFE_0012);
        step(0, '0, 1, 6'd12, 32'hCAFE_0012);
        chk("starve_vld_cnt", rd_cnt - c0, 10);
        step(1, 6'd11, 0, '0, '0);
        step(1, 6'd12, 0, '0, '0);
        step(0, '0, 0, '0, '0);
        step(0, '0, 0, '0, '0);

        // Reset in the middle of a sweep.
        do_clear(20);

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/db_tupu_ram_ctrl.md
Name: db_tupu_ram_ctrl

Overview:
Client-side access controller for the deblocking top-PU single-port buffer (64 words x 32 bits, low-active CEN/WEN, 1-cycle read latency).
- Presents independent write and read request ports to the deblocking datapath.
- Arbitrates both ports onto the single RAM port, with read priority.
- Holds a one-entry write buffer so that no accepted write is ever lost.
- Runs a sweep that clears the whole buffer on command.
- The RAM itself is instantiated next to this block in the deblocking top.

Parameters:
- ADR_W, 6, RAM address width; depth is 2**ADR_W.
- DAT_W, 32, RAM word width.
- CLR_VAL, 0, word written to every address during a clear sweep.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr_start_i  in  1  one-cycle pulse; starts a clear sweep
- busy_o  out  1  high while the clear sweep runs
- clr_done_o  out  1  one-cycle pulse after the last clear write
- wr_req_i  in  1  write request
- wr_adr_i  in  ADR_W  write address
- wr_dat_i  in  DAT_W  write data
- wr_rdy_o  out  1  write accepted when wr_req_i & wr_rdy_o
- rd_req_i  in  1  read request, accepted when rd_req_i & rd_rdy_o
- rd_adr_i  in  ADR_W  read address
- rd_rdy_o  out  1  read port ready
- rd_vld_o  out  1  read data valid, registered
- rd_dat_o  out  DAT_W  read data
- ram_cen_o  out  1  RAM chip enable, low active
- ram_wen_o  out  1  RAM write enable, low active
- ram_adr_o  out  ADR_W  RAM address
- ram_wr_dat_o  out  DAT_W  RAM write data
- ram_rd_dat_i  in  DAT_W  RAM Q, valid one cycle after a read

Behaviour:
- Reset: FSM=IDLE, wb_vld=0, clr_cnt=0, rd_vld_o=0, clr_done_o=0, busy_o=0. With no request present, ram_cen_o=1, ram_wen_o=1, ram_adr_o=0, ram_wr_dat_o=0.
- FSM states: IDLE, CLR.
  - IDLE -> CLR on clr_start_i. This takes precedence over requests in the same cycle, and those requests are not accepted.
  - CLR -> IDLE after the write at address 2**ADR_W-1.
- CLR state:
  - ram_cen_o=0, ram_wen_o=0, ram_adr_o=clr_cnt, ram_wr_dat_o=CLR_VAL; clr_cnt increments each cycle. A full sweep takes exactly 64 cycles.
  - busy_o=1, wr_rdy_o=0, rd_rdy_o=0.
  - clr_done_o pulses in the first IDLE cycle after the sweep.
  - clr_start_i during CLR is ignored; clr_cnt is not restarted.
  - A pending wb_vld entry is discarded on entry to CLR.
- IDLE port readiness: rd_rdy_o=1; wr_rdy_o = ~wb_vld.
- RAM port priority in IDLE, evaluated combinationally each cycle:
  1. Accepted read: ram_cen_o=0, ram_wen_o=1, ram_adr_o=rd_adr_i.
  2. Else, if wb_vld: write the buffer (ram_wen_o=0) and clear wb_vld.
  3. Else, accepted write: write straight through (ram_wen_o=0, ram_adr_o=wr_adr_i).
  4. Else: ram_cen_o=1.
- Write accepted in the same cycle as a read: captured in wb_adr/wb_dat, wb_vld=1. It drains on the first later IDLE cycle with no read.
- Read latency: 1 cycle. rd_vld_o=1 in cycle N+1 for a read accepted in cycle N; rd_dat_o=ram_rd_dat_i unless forwarded (see Optional Feature).
- Back-to-back reads sustain 1 per cycle. Continuous reads starve the write buffer; wr_rdy_o stays 0 meanwhile, with no loss of data.
- Reset asserted mid-sweep: the sweep aborts and no clr_done_o is issued. RAM contents are undefined until the next clear.
- Addresses wrap naturally at ADR_W bits. There is no out-of-range case.

Optional Feature:
- Macro: DB_TUPU_FWD_EN.
- Defined: a read whose address equals a pending buffered write (wb_vld & wb_adr==rd_adr_i), or equals a write accepted in the same cycle, returns that write's data. This is done through a registered select/data pair muxed onto rd_dat_o in cycle N+1. Same-cycle accepted write wins over the buffer.
- Not defined: rd_dat_o is always ram_rd_dat_i, so such reads return the old RAM contents. The datapath owner guarantees this hazard is never exercised.

Decomposition:
- Shared package / enc_defines: ADR_W, DAT_W, CLR_VAL, and FSM state encodings (ST_IDLE, ST_CLR).
- No sub-module. The write buffer and forwarding mux are small enough to live inline.
- The RAM instance lives in the parent.

Test Plan:
1. Clear: clr_start_i pulse -> busy_o high 64 cycles, ram_adr_o 0..63 with WEN=0 and data 0; clr_done_o one pulse; a later read of address 63 returns 0.
2. Write then read: write adr 5 data 0xDEADBEEF, idle one cycle, read adr 5 -> rd_vld_o one cycle later, rd_dat_o=0xDEADBEEF.
3. Simultaneous: read adr 1 plus write adr 2 data 0x12345678 in the same cycle -> RAM read in that cycle, wb_vld=1, wr_rdy_o=0; next idle cycle RAM write adr 2; a later read of adr 2 returns 0x12345678.
4. Hazard: same cycle as scenario 3 but read adr 2 -> with DB_TUPU_FWD_EN returns 0x12345678; without it returns the prior RAM value.
5. Starvation: 10 consecutive reads with a write pending -> write drains on cycle 11, and 10 rd_vld_o pulses occur.
6. Reset mid-sweep: rst_n low at sweep cycle 20 -> outputs return to reset values immediately; no clr_done_o; wr_rdy_o=1 after release.
